// File: rtl/ball_scan.sv
// rtl/ball_scan.sv - ball renderer with frame-latched position and optional collision
// reporting (enabled by defining BALL_COLLIDE_EN).
module ball_scan #(
  parameter int BALL_SIZE    = 4,
  parameter int BALL_STRETCH = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       display_on,
  input  logic       frame_start,
  input  logic [8:0] ball_hpos,
  input  logic [8:0] ball_vpos,
  input  logic       playfield_gfx,
  input  logic       paddle_gfx,
  input  logic       collide_ack,
  output logic       ball_gfx,
  output logic       hit_wall,
  output logic       hit_paddle,
  output logic       collide_valid
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ROWS = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int         LINES     = (BALL_STRETCH != 0) ? 2 * BALL_SIZE : BALL_SIZE;
  localparam logic [4:0] LAST_LINE = 5'(LINES - 1);

  logic [8:0] shadow_h_q, shadow_h_d;
  logic [8:0] shadow_v_q, shadow_v_d;
  logic [8:0] vpos_prev_q;
  logic [1:0] state_q, state_d;
  logic [4:0] line_q, line_d;
  logic       armed_q, armed_d;
  logic       gfx_q;
  logic       in_ball;

  // armed_q keeps the zeroed shadow position from drawing before the first frame_start
  always_comb begin
    shadow_h_d = shadow_h_q;
    shadow_v_d = shadow_v_q;
    armed_d    = armed_q;
    state_d    = state_q;
    line_d     = line_q;
    if (frame_start) begin
      shadow_h_d = ball_hpos;
      shadow_v_d = ball_vpos;
      armed_d    = 1'b1;
      state_d    = ST_IDLE;
      line_d     = 5'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (armed_q && (vpos == shadow_v_q)) begin
            state_d = ST_ROWS;
            line_d  = 5'd0;
          end
        end
        ST_ROWS: begin
          if (vpos != vpos_prev_q) begin
            if (line_q == LAST_LINE) begin
              state_d = ST_DONE;
            end else begin
              line_d = line_q + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // 10-bit compare so a ball near the right edge clips instead of wrapping to column 0
  logic [9:0] h_ext, h_lo, h_hi;
  assign h_ext   = {1'b0, hpos};
  assign h_lo    = {1'b0, shadow_h_q};
  assign h_hi    = h_lo + 10'(BALL_SIZE);
  assign in_ball = (state_q == ST_ROWS) && display_on && (h_ext >= h_lo) && (h_ext < h_hi);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_h_q  <= 9'd0;
      shadow_v_q  <= 9'd0;
      vpos_prev_q <= 9'd0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      line_q      <= 5'd0;
      gfx_q       <= 1'b0;
    end else begin
      shadow_h_q  <= shadow_h_d;
      shadow_v_q  <= shadow_v_d;
      vpos_prev_q <= vpos;
      armed_q     <= armed_d;
      state_q     <= state_d;
      line_q      <= line_d;
      gfx_q       <= in_ball;
    end
  end

  assign ball_gfx = gfx_q;

`ifdef BALL_COLLIDE_EN
  logic acc_wall_q, acc_wall_d;
  logic acc_pad_q, acc_pad_d;
  logic hit_wall_q, hit_wall_d;
  logic hit_pad_q, hit_pad_d;
  logic valid_q, valid_d;
  logic wall_now, pad_now;

  assign wall_now = in_ball & playfield_gfx;
  assign pad_now  = in_ball & paddle_gfx;

  // a hit in the frame_start cycle seeds the new frame, never the report being handed over
  always_comb begin
    acc_wall_d = acc_wall_q | wall_now;
    acc_pad_d  = acc_pad_q | pad_now;
    hit_wall_d = hit_wall_q;
    hit_pad_d  = hit_pad_q;
    valid_d    = valid_q;
    if (frame_start) begin
      acc_wall_d = wall_now;
      acc_pad_d  = pad_now;
      hit_wall_d = acc_wall_q;
      hit_pad_d  = acc_pad_q;
      valid_d    = acc_wall_q | acc_pad_q;
    end else if (valid_q && collide_ack) begin
      hit_wall_d = 1'b0;
      hit_pad_d  = 1'b0;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_wall_q <= 1'b0;
      acc_pad_q  <= 1'b0;
      hit_wall_q <= 1'b0;
      hit_pad_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      acc_wall_q <= acc_wall_d;
      acc_pad_q  <= acc_pad_d;
      hit_wall_q <= hit_wall_d;
      hit_pad_q  <= hit_pad_d;
      valid_q    <= valid_d;
    end
  end

  assign hit_wall      = hit_wall_q;
  assign hit_paddle    = hit_pad_q;
  assign collide_valid = valid_q;
`else
  logic unused_collide_inputs;
  assign unused_collide_inputs = playfield_gfx ^ paddle_gfx ^ collide_ack;

  assign hit_wall      = 1'b0;
  assign hit_paddle    = 1'b0;
  assign collide_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ball_scan.sv
// tb/tb_ball_scan.sv - directed-vector bench for ball_scan; report checks follow BALL_COLLIDE_EN.
module tb_ball_scan;

`ifdef BALL_COLLIDE_EN
  localparam bit COL = 1'b1;
`else
  localparam bit COL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos, vpos, ball_hpos, ball_vpos;
  logic       display_on, frame_start, playfield_gfx, paddle_gfx, collide_ack;
  logic       ball_gfx, hit_wall, hit_paddle, collide_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ball_scan #(.BALL_SIZE(4), .BALL_STRETCH(0)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .frame_start(frame_start), .ball_hpos(ball_hpos), .ball_vpos(ball_vpos),
    .playfield_gfx(playfield_gfx), .paddle_gfx(paddle_gfx), .collide_ack(collide_ack),
    .ball_gfx(ball_gfx), .hit_wall(hit_wall), .hit_paddle(hit_paddle),
    .collide_valid(collide_valid)
  );

  function automatic bit model(input int h, input int v, input int bh, input int bv);
    return (v >= bv) && (v < bv + 4) && (h >= bh) && (h < bh + 4);
  endfunction

  task automatic step(input int h, input int v, input bit disp, input bit fs, input bit pf,
                      input bit pd, input bit ack, input bit exp_gfx, input string name);
    hpos = 9'(h); vpos = 9'(v); display_on = disp; frame_start = fs;
    playfield_gfx = pf; paddle_gfx = pd; collide_ack = ack;
    @(posedge clk);
    #1;
    total++;
    if (ball_gfx !== exp_gfx) begin
      bad++;
      $display("FAIL %s ball_gfx h=%0d v=%0d: got %b want %b", name, h, v, ball_gfx, exp_gfx);
    end
  endtask

  task automatic scan(input int bh, input int bv, input int v0, input int v1, input int h0,
                      input int hn, input int pfh, input int pfv, input int pdh, input int pdv,
                      input string name);
    for (int v = v0; v <= v1; v++) begin
      for (int k = 0; k < hn; k++) begin
        int h;
        h = (h0 + k) % 512;
        step(h, v, 1'b1, 1'b0, (h == pfh) && (v == pfv), (h == pdh) && (v == pdv), 1'b0,
             model(h, v, bh, bv), name);
      end
    end
  endtask

  task automatic frame(input int h, input int v, input bit disp, input bit pf, input bit ack,
                       input bit exp_gfx, input bit exp_w, input bit exp_p, input string name);
    step(h, v, disp, 1'b1, pf, 1'b0, ack, exp_gfx, name);
    total += 3;
    if (hit_wall !== (COL & exp_w)) begin
      bad++;
      $display("FAIL %s hit_wall: got %b want %b", name, hit_wall, COL & exp_w);
    end
    if (hit_paddle !== (COL & exp_p)) begin
      bad++;
      $display("FAIL %s hit_paddle: got %b want %b", name, hit_paddle, COL & exp_p);
    end
    if (collide_valid !== (COL & (exp_w | exp_p))) begin
      bad++;
      $display("FAIL %s collide_valid: got %b want %b", name, collide_valid, COL & (exp_w | exp_p));
    end
  endtask

  task automatic vblank_frame(input bit ack, input bit exp_w, input bit exp_p, input string name);
    frame(0, 300, 1'b0, 1'b0, ack, 1'b0, exp_w, exp_p, name);
  endtask

  task automatic test_reset;
    reset = 1'b0; hpos = '0; vpos = '0; ball_hpos = '0; ball_vpos = '0;
    display_on = 1'b0; frame_start = 1'b0; playfield_gfx = 1'b0; paddle_gfx = 1'b0;
    collide_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ball_gfx, hit_wall, hit_paddle, collide_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL reset outputs: got %b want 0000", {ball_gfx, hit_wall, hit_paddle, collide_valid});
    end
    reset = 1'b1;
    for (int h = 0; h < 4; h++) step(h, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pre_frame");
  endtask

  task automatic test_basic;
    ball_hpos = 9'd20; ball_vpos = 9'd20;
    vblank_frame(1'b0, 1'b0, 1'b0, "basic_fs");
    scan(20, 20, 18, 25, 16, 12, -1, -1, -1, -1, "basic");
  endtask

  task automatic test_no_tear;
    vblank_frame(1'b0, 1'b0, 1'b0, "tear_fs1");
    scan(20, 20, 18, 19, 16, 12, -1, -1, -1, -1, "tear_old");
    ball_hpos = 9'd100;
    scan(20, 20, 20, 25, 16, 12, -1, -1, -1, -1, "tear_old_mid");
    scan(20, 20, 20, 20, 96, 12, -1, -1, -1, -1, "tear_not_new");
    vblank_frame(1'b0, 1'b0, 1'b0, "tear_fs2");
    scan(100, 20, 18, 25, 96, 12, -1, -1, -1, -1, "tear_new");
  endtask

  task automatic test_clip;
    ball_hpos = 9'd510;
    vblank_frame(1'b0, 1'b0, 1'b0, "clip_fs");
    scan(510, 20, 19, 24, 506, 12, -1, -1, -1, -1, "clip");
  endtask

  task automatic test_collision;
    ball_hpos = 9'd20;
    vblank_frame(1'b0, 1'b0, 1'b0, "col_fs0");
    scan(20, 20, 18, 25, 16, 12, 22, 21, -1, -1, "col_scan");
    vblank_frame(1'b0, 1'b1, 1'b0, "col_report");
    for (int i = 0; i < 3; i++) begin
      step(0, 300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "col_hold");
      total++;
      if ({hit_wall, hit_paddle, collide_valid} !== {COL, 1'b0, COL}) begin
        bad++;
        $display("FAIL col_hold report: got %b want %b", {hit_wall, hit_paddle, collide_valid},
                 {COL, 1'b0, COL});
      end
    end
    step(0, 300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "col_ack");
    total++;
    if ({hit_wall, hit_paddle, collide_valid} !== 3'b000) begin
      bad++;
      $display("FAIL col_ack clear: got %b want 000", {hit_wall, hit_paddle, collide_valid});
    end
    step(0, 300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "col_ack_idle");
    total++;
    if ({hit_wall, hit_paddle, collide_valid} !== 3'b000) begin
      bad++;
      $display("FAIL col_ack_idle: got %b want 000", {hit_wall, hit_paddle, collide_valid});
    end
  endtask

  task automatic test_newest;
    scan(20, 20, 18, 25, 16, 12, -1, -1, 21, 22, "new_pad");
    vblank_frame(1'b0, 1'b0, 1'b1, "new_pad_rep");
    scan(20, 20, 18, 25, 16, 12, -1, -1, -1, -1, "new_none");
    vblank_frame(1'b0, 1'b0, 1'b0, "new_overwrite");
    scan(20, 20, 18, 25, 16, 12, -1, -1, 21, 22, "new_pad2");
    vblank_frame(1'b0, 1'b0, 1'b1, "new_pad2_rep");
    scan(20, 20, 18, 25, 16, 12, 22, 22, -1, -1, "new_wall");
    vblank_frame(1'b1, 1'b1, 1'b0, "ack_at_fs");
  endtask

  task automatic test_fs_collision;
    scan(20, 20, 18, 21, 16, 12, -1, -1, -1, -1, "fs_col_pre");
    frame(22, 21, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "fs_col_transfer");
    scan(20, 20, 18, 25, 16, 12, -1, -1, -1, -1, "fs_col_next");
    vblank_frame(1'b0, 1'b1, 1'b0, "fs_col_counted");
  endtask

  task automatic test_reset_mid;
    scan(20, 20, 18, 21, 16, 12, -1, -1, 21, 21, "rst_pre");
    step(21, 22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "rst_pre_pix");
    reset = 1'b0;
    #1;
    total++;
    if ({ball_gfx, hit_wall, hit_paddle, collide_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_async outputs: got %b want 0000", {ball_gfx, hit_wall, hit_paddle, collide_valid});
    end
    for (int i = 0; i < 3; i++) step(22, 22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rst_hold");
    reset = 1'b1;
    scan(20, -100, 22, 25, 16, 12, -1, -1, 22, 22, "rst_after");
    vblank_frame(1'b0, 1'b0, 1'b0, "rst_no_report");
    scan(20, 20, 19, 24, 16, 12, -1, -1, -1, -1, "rst_recover");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_no_tear;
    test_clip;
    test_collision;
    test_newest;
    test_fs_collision;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
